// File: rtl/egd_bitstream_ctrl.sv
// Bitstream sequencer for the Exp-Golomb decode core: MSB-first bit buffer, decoder handshake, internal u(n) reads.
// Optional statistics counters are enabled with `define EGD_CTRL_STATS_EN.
module egd_bitstream_ctrl #(
  parameter  int BUF_W  = 64,
  parameter  int WORD_W = 32,
  localparam int LVL_W  = $clog2(BUF_W + 1)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_mode,
  input  logic [3:0]        req_nbits,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [15:0]       res_value,
  output logic [4:0]        res_len,
  output logic              res_err,
  output logic [15:0]       egd_window,
  output logic [1:0]        egd_mode,
  input  logic [7:0]        egd_value,
  input  logic [3:0]        egd_len,
  output logic [LVL_W-1:0]  level
`ifdef EGD_CTRL_STATS_EN
  ,
  output logic [15:0]       stat_elems,
  output logic [7:0]        stat_errs,
  output logic [23:0]       stat_bits
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_live;
  logic [BUF_W-1:0]    r_buf;
  logic [LVL_W-1:0]    r_level;
  logic [1:0]          r_mode;
  logic [4:0]          r_nbits;
  logic [15:0]         r_res_value;
  logic [4:0]          r_res_len;
  logic                r_res_err;

  logic                w_word_acc, w_req_acc, w_exec, w_err;
  logic [15:0]         w_top, w_val;
  logic [4:0]          w_len, w_cons, w_need_req, w_need_lat;
  logic [LVL_W-1:0]    w_lvl_sub, w_lvl_nxt;
  logic [BUF_W-1:0]    w_buf_nxt, w_word_ins;

  assign w_word_acc = word_valid & word_ready;
  assign w_req_acc  = req_valid & req_ready;
  assign w_exec     = (r_state == S_EXEC) & ~flush;
  assign w_top      = r_buf[BUF_W-1 -: 16];

  assign w_need_req = (req_mode == 2'b11) ? ((req_nbits == 4'd0) ? 5'd16 : {1'b0, req_nbits}) : 5'd16;
  assign w_need_lat = (r_mode == 2'b11) ? r_nbits : 5'd16;

  // Result of the current element; mode 11 never looks at the decoder.
  always_comb begin
    w_len = 5'd0;
    w_val = 16'd0;
    w_err = 1'b0;
    if (r_mode == 2'b11) begin
      w_len = r_nbits;
      w_val = w_top >> (5'd16 - r_nbits);
    end else if (egd_len == 4'd0) begin
      w_err = 1'b1;
    end else begin
      w_len = {1'b0, egd_len};
      w_val = {8'd0, egd_value};
    end
  end

  // Consume first, then append any incoming word right behind the surviving bits.
  assign w_cons     = w_exec ? w_len : 5'd0;
  assign w_lvl_sub  = r_level - LVL_W'(w_cons);
  assign w_word_ins = {word_data, {(BUF_W-WORD_W){1'b0}}} >> w_lvl_sub;
  assign w_lvl_nxt  = flush ? '0 : (w_lvl_sub + (w_word_acc ? LVL_W'(WORD_W) : '0));
  assign w_buf_nxt  = flush ? '0 : ((r_buf << w_cons) | (w_word_acc ? w_word_ins : '0));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Entry to EXEC is judged on next-cycle level so a word landing this cycle counts.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_req_acc) w_state_nxt = (w_lvl_nxt >= LVL_W'(w_need_req)) ? S_EXEC : S_WAIT;
      S_WAIT: begin
        if (flush)                                   w_state_nxt = S_IDLE;
        else if (w_lvl_nxt >= LVL_W'(w_need_lat))    w_state_nxt = S_EXEC;
      end
      S_EXEC: w_state_nxt = flush ? S_IDLE : S_RESP;
      S_RESP: if (res_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = r_live & (r_state == S_IDLE);
    res_valid  = (r_state == S_RESP);
    word_ready = r_live & (r_level <= LVL_W'(BUF_W - WORD_W)) & ~flush;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_live      <= 1'b0;
      r_buf       <= '0;
      r_level     <= '0;
      r_mode      <= 2'b00;
      r_nbits     <= 5'd0;
      r_res_value <= 16'd0;
      r_res_len   <= 5'd0;
      r_res_err   <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_buf   <= w_buf_nxt;
      r_level <= w_lvl_nxt;
      if (w_req_acc) begin
        r_mode  <= req_mode;
        r_nbits <= w_need_req;
      end
      if (w_exec) begin
        r_res_value <= w_val;
        r_res_len   <= w_len;
        r_res_err   <= w_err;
      end
    end
  end

  assign egd_window = w_top;
  assign egd_mode   = r_mode;
  assign level      = r_level;
  assign res_value  = r_res_value;
  assign res_len    = r_res_len;
  assign res_err    = r_res_err;

`ifdef EGD_CTRL_STATS_EN
  logic [24:0] w_bits_sum;
  assign w_bits_sum = {1'b0, stat_bits} + 25'(w_len);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      stat_elems <= '0;
      stat_errs  <= '0;
      stat_bits  <= '0;
    end else if (w_exec) begin
      if (w_err) begin
        if (stat_errs != '1) stat_errs <= stat_errs + 8'd1;
      end else begin
        if (stat_elems != '1) stat_elems <= stat_elems + 16'd1;
      end
      stat_bits <= w_bits_sum[24] ? '1 : w_bits_sum[23:0];
    end
  end
`endif

endmodule

// File: tb/tb_egd_bitstream_ctrl.sv
// Directed bench for egd_bitstream_ctrl with a behavioural Exp-Golomb decoder attached to the window.
module tb_egd_bitstream_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] word_data = '0;
  logic        word_valid = 1'b0, word_ready;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_mode = 2'b00;
  logic [3:0]  req_nbits = 4'd0;
  logic        res_valid, res_ready = 1'b0;
  logic [15:0] res_value;
  logic [4:0]  res_len;
  logic        res_err;
  logic [15:0] egd_window;
  logic [1:0]  egd_mode;
  logic [7:0]  egd_value;
  logic [3:0]  egd_len;
  logic [6:0]  level;
`ifdef EGD_CTRL_STATS_EN
  logic [15:0] stat_elems;
  logic [7:0]  stat_errs;
  logic [23:0] stat_bits;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  egd_bitstream_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_nbits(req_nbits),
    .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value), .res_len(res_len),
    .res_err(res_err),
    .egd_window(egd_window), .egd_mode(egd_mode), .egd_value(egd_value), .egd_len(egd_len),
    .level(level)
`ifdef EGD_CTRL_STATS_EN
    , .stat_elems(stat_elems), .stat_errs(stat_errs), .stat_bits(stat_bits)
`endif
  );

  // Reference decoder: ue/te straight, se mapped; >15-bit codewords are invalid.
  always_comb begin
    int lz;
    int k;
    lz = 16;
    k  = 0;
    for (int i = 0; i < 16; i++) if (egd_window[15-i] && lz == 16) lz = i;
    egd_len   = 4'd0;
    egd_value = 8'd0;
    if (lz <= 7) begin
      k = (1 << lz) - 1 + int'((egd_window >> (15 - 2*lz)) & ((16'd1 << lz) - 16'd1));
      egd_len = 4'(2*lz + 1);
      if (egd_mode == 2'b01) egd_value = (k % 2 == 1) ? 8'((k + 1) / 2) : 8'(-(k / 2));
      else                   egd_value = 8'(k);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    int n;
    @(negedge clk);
    word_data = w; word_valid = 1'b1;
    n = 0;
    while (!word_ready && n < 50) begin @(negedge clk); n++; end
    if (!word_ready) chk("push_timeout", {31'd0, word_ready}, 32'd1);
    @(posedge clk); #1 word_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  task automatic send_req(input logic [1:0] m, input logic [3:0] nb);
    int n;
    @(negedge clk);
    req_mode = m; req_nbits = nb; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic get_res(output logic [15:0] v, output logic [4:0] l, output logic e);
    int n;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    if (!res_valid) chk("res_timeout", {31'd0, res_valid}, 32'd1);
    v = res_value; l = res_len; e = res_err;
    res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
  endtask

  task automatic do_req(input logic [1:0] m, input logic [3:0] nb,
                        output logic [15:0] v, output logic [4:0] l, output logic e);
    send_req(m, nb);
    get_res(v, l, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic [4:0]  l;
    logic        e;
    logic [31:0] w1, w2;
    logic [63:0] s;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_level", {25'd0, level}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_word_ready", {31'd0, word_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_word_ready", {31'd0, word_ready}, 32'd1);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // 1: three ue codewords 1 / 010 / 011
    push(32'hA600_0000);
    push(32'h0000_0000);
    @(negedge clk);
    chk("t1_level64", {25'd0, level}, 32'd64);
    do_req(2'b00, 4'd0, v, l, e);
    chk("t1_v0", {16'd0, v}, 32'd0);
    chk("t1_l0", {27'd0, l}, 32'd1);
    do_req(2'b00, 4'd0, v, l, e);
    chk("t1_v1", {16'd0, v}, 32'd1);
    chk("t1_l1", {27'd0, l}, 32'd3);
    do_req(2'b00, 4'd0, v, l, e);
    chk("t1_v2", {16'd0, v}, 32'd2);
    chk("t1_l2", {27'd0, l}, 32'd3);
    chk("t1_err", {31'd0, e}, 32'd0);
    @(negedge clk);
    chk("t1_level57", {25'd0, level}, 32'd57);
`ifdef EGD_CTRL_STATS_EN
    chk("t1_stat_elems", {16'd0, stat_elems}, 32'd3);
    chk("t1_stat_bits", {8'd0, stat_bits}, 32'd7);
`endif

    // 2: fixed-length reads
    do_flush();
    @(negedge clk);
    chk("t2_flush_level", {25'd0, level}, 32'd0);
    push(32'hDEAD_BEEF);
    @(negedge clk);
    chk("t2_window", {16'd0, egd_window}, 32'h0000_DEAD);
    do_req(2'b11, 4'd8, v, l, e);
    chk("t2_u8_v", {16'd0, v}, 32'h0000_00DE);
    chk("t2_u8_l", {27'd0, l}, 32'd8);
    @(negedge clk);
    chk("t2_level24", {25'd0, level}, 32'd24);
    do_req(2'b11, 4'd0, v, l, e);
    chk("t2_u16_v", {16'd0, v}, 32'h0000_ADBE);
    chk("t2_u16_l", {27'd0, l}, 32'd16);
    @(negedge clk);
    chk("t2_level8", {25'd0, level}, 32'd8);

    // 3: starvation then word arrival
    do_flush();
    send_req(2'b00, 4'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t3_starved", {31'd0, res_valid}, 32'd0);
    end
    word_data = 32'h8000_0000; word_valid = 1'b1;
    @(posedge clk); #1 word_valid = 1'b0;
    @(negedge clk);
    chk("t3_exec_no_valid", {31'd0, res_valid}, 32'd0);
    chk("t3_exec_level", {25'd0, level}, 32'd32);
    @(negedge clk);
    chk("t3_res_valid", {31'd0, res_valid}, 32'd1);
    chk("t3_v", {16'd0, res_value}, 32'd0);
    chk("t3_l", {27'd0, res_len}, 32'd1);
    chk("t3_level", {25'd0, level}, 32'd31);
    res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;

    // 4: word accept concurrent with a 3-bit consume
    do_flush();
    w1 = 32'h4BCD_1234;
    w2 = 32'h8765_4321;
    s  = {w1[28:0], w2, 3'b000};
    push(w1);
    send_req(2'b00, 4'd0);
    @(negedge clk);
    chk("t4_word_ready", {31'd0, word_ready}, 32'd1);
    word_data = w2; word_valid = 1'b1;
    @(posedge clk); #1 word_valid = 1'b0;
    @(negedge clk);
    chk("t4_res_valid", {31'd0, res_valid}, 32'd1);
    chk("t4_v", {16'd0, res_value}, 32'd1);
    chk("t4_l", {27'd0, res_len}, 32'd3);
    chk("t4_level61", {25'd0, level}, 32'd61);
    res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    do_req(2'b11, 4'd0, v, l, e);
    chk("t4_u16_a", {16'd0, v}, {16'd0, s[63:48]});
    do_req(2'b11, 4'd0, v, l, e);
    chk("t4_u16_b", {16'd0, v}, {16'd0, s[47:32]});
    do_req(2'b11, 4'd0, v, l, e);
    chk("t4_u16_c", {16'd0, v}, {16'd0, s[31:16]});
    do_req(2'b11, 4'd13, v, l, e);
    chk("t4_u13", {16'd0, v}, {19'd0, s[15:3]});
    @(negedge clk);
    chk("t4_level0", {25'd0, level}, 32'd0);

    // 5: invalid codeword
    do_flush();
    push(32'h0);
    push(32'h0);
    do_req(2'b00, 4'd0, v, l, e);
    chk("t5_err", {31'd0, e}, 32'd1);
    chk("t5_v", {16'd0, v}, 32'd0);
    chk("t5_l", {27'd0, l}, 32'd0);
    @(negedge clk);
    chk("t5_level", {25'd0, level}, 32'd64);
`ifdef EGD_CTRL_STATS_EN
    chk("t5_stat_errs", {24'd0, stat_errs}, 32'd1);
    chk("t5_stat_elems", {16'd0, stat_elems}, 32'd0);
`endif

    // 6a: flush while waiting
    do_flush();
    send_req(2'b00, 4'd0);
    do_flush();
    @(negedge clk);
    chk("t6_req_ready", {31'd0, req_ready}, 32'd1);
    chk("t6_level", {25'd0, level}, 32'd0);
    chk("t6_no_valid", {31'd0, res_valid}, 32'd0);
    repeat (2) @(negedge clk);
    chk("t6_no_valid_late", {31'd0, res_valid}, 32'd0);

    // 6b: reset while a result is pending
    push(32'h8000_0000);
    send_req(2'b00, 4'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_pending", {31'd0, res_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_valid", {31'd0, res_valid}, 32'd0);
    chk("t6_rst_level", {25'd0, level}, 32'd0);
    chk("t6_rst_len", {27'd0, res_len}, 32'd0);
    chk("t6_rst_window", {16'd0, egd_window}, 32'd0);
    chk("t6_rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("t6_rst_word_ready", {31'd0, word_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rel_word_ready", {31'd0, word_ready}, 32'd1);
    chk("t6_rel_req_ready", {31'd0, req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
